// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - multi-channel soft clock divider with glitch-free ratio reload and lock flag
// Optional settle-based lock logic is enabled by defining CLKDIV_LOCK_EN.
module clk_div_gen #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 16,
  parameter int DEF_DIV     = 24,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                    clkin,
  input  logic                    reset,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  output logic [NUM_CH-1:0]       div_ack,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       clkout,
  output logic                    lock
);

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF_VAL = DIV_W'(DEF_DIV);

  if (NUM_CH < 1 || NUM_CH > 8 || DIV_W < 1 || LOCK_CYCLES < 0) begin : g_bad_cfg
    $error("clk_div_gen: unsupported parameter set");
  end

`ifdef CLKDIV_LOCK_EN
  logic [NUM_CH-1:0] wrap_all;
  logic [NUM_CH-1:0] apply_all;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_cur;
    logic [DIV_W-1:0] pend_val;
    logic             pend_vld;
    logic [DIV_W-1:0] d_eff;
    logic [DIV_W-1:0] d_last;
    logic [DIV_W-1:0] high_t;
    logic             wrap;
    logic             apply;
    logic             out_q;
    logic             en_q;
    logic             ack_q;

    // A programmed ratio of zero runs as divide-by-one.
    always_comb begin
      d_eff  = (div_cur == '0) ? ONE : div_cur;
      d_last = d_eff - ONE;
      high_t = d_eff - (d_eff >> 1);
    end

    assign wrap  = (cnt == d_last);
    assign apply = wrap & pend_vld;

    always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
        cnt      <= '0;
        div_cur  <= DEF_VAL;
        pend_val <= '0;
        pend_vld <= 1'b0;
        out_q    <= 1'b0;
        en_q     <= 1'b0;
        ack_q    <= 1'b0;
      end else begin
        out_q <= (cnt < high_t);
        en_q  <= wrap;
        ack_q <= apply;

        if (apply) begin
          div_cur <= pend_val;
          cnt     <= '0;
        end else if (wrap) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + ONE;
        end

        // A load landing on the apply edge stays pending for the next wrap.
        if (div_load[i]) begin
          pend_val <= div_val[i*DIV_W +: DIV_W];
          pend_vld <= 1'b1;
        end else if (apply) begin
          pend_vld <= 1'b0;
        end
      end
    end

    assign clkout[i]  = out_q;
    assign clk_en[i]  = en_q;
    assign div_ack[i] = ack_q;

`ifdef CLKDIV_LOCK_EN
    assign wrap_all[i]  = wrap;
    assign apply_all[i] = apply;
`endif
  end

`ifdef CLKDIV_LOCK_EN
  localparam int SW = $clog2(LOCK_CYCLES + 2);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(LOCK_CYCLES);

  logic [SW-1:0]     settle;
  logic [NUM_CH-1:0] seen;

  // Any ratio change restarts settling and forgets which channels have ticked.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      settle <= '0;
      seen   <= '0;
      lock   <= 1'b0;
    end else if (|apply_all) begin
      settle <= '0;
      seen   <= '0;
      lock   <= 1'b0;
    end else begin
      if (settle != SETTLE_MAX) begin
        settle <= settle + SW'(1);
      end
      seen <= seen | wrap_all;
      lock <= (settle == SETTLE_MAX) && (&seen);
    end
  end
`else
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock <= 1'b0;
    end else begin
      lock <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - scoreboard bench for clk_div_gen
// Expected event cycles are queued per output; a monitor pops and compares.
module tb_clk_div_gen;

  localparam int NUM_CH      = 2;
  localparam int DIV_W       = 16;
  localparam int DEF_DIV     = 24;
  localparam int LOCK_CYCLES = 16;
  localparam int EN = 0, ACK = 1, RISE = 2, FALL = 3;
  localparam int LOCK_R = 8, LOCK_F = 9, NUM_EV = 10;

  logic                    clk;
  logic                    reset;
  logic [NUM_CH*DIV_W-1:0] div_val;
  logic [NUM_CH-1:0]       div_load;
  logic [NUM_CH-1:0]       div_ack;
  logic [NUM_CH-1:0]       clk_en;
  logic [NUM_CH-1:0]       clkout;
  logic                    lock;

  clk_div_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clkin(clk), .reset(reset), .div_val(div_val), .div_load(div_load),
    .div_ack(div_ack), .clk_en(clk_en), .clkout(clkout), .lock(lock)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  int mon_until = 0;
  bit lock_mon;
  int exp_q [NUM_EV][$];
  logic [NUM_CH-1:0] prev_out = '0;
  logic prev_lock = 1'b0;
  string ev_name [NUM_EV] = '{"clk_en[0]", "clk_en[1]", "div_ack[0]", "div_ack[1]",
                              "clkout_rise[0]", "clkout_rise[1]", "clkout_fall[0]",
                              "clkout_fall[1]", "lock_rise", "lock_fall"};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_ev(input int idx);
    int e;
    checks++;
    if (exp_q[idx].size() == 0) begin
      errors++;
      $display("FAIL %s: event at cycle %0d, required no event", ev_name[idx], cyc);
    end else begin
      e = exp_q[idx].pop_front();
      if (e != cyc) begin
        errors++;
        $display("FAIL %s: event at cycle %0d, required cycle %0d", ev_name[idx], cyc, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset && mon_until != 0 && cyc <= mon_until) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clk_en[i])                 check_ev(EN * NUM_CH + i);
        if (div_ack[i])                check_ev(ACK * NUM_CH + i);
        if (clkout[i] && !prev_out[i]) check_ev(RISE * NUM_CH + i);
        if (!clkout[i] && prev_out[i]) check_ev(FALL * NUM_CH + i);
      end
      if (lock_mon) begin
        if (lock && !prev_lock) check_ev(LOCK_R);
        if (!lock && prev_lock) check_ev(LOCK_F);
      end
    end
    prev_out  <= clkout;
    prev_lock <= lock;
  end

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc != n) begin
      errors++;
      $display("FAIL wait_cyc: at cycle %0d, required cycle %0d", cyc, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_until = 0;
    reset     = 1'b1;
    div_load  = '0;
    #1;
    cmp("reset clk_en", int'(clk_en), 0);
    cmp("reset clkout", int'(clkout), 0);
    cmp("reset div_ack", int'(div_ack), 0);
    cmp("reset lock", int'(lock), 0);
    for (int i = 0; i < NUM_EV; i++) exp_q[i].delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push(input int idx, input int c);
    exp_q[idx].push_back(c);
  endtask

  task automatic push_seq(input int idx, input int first, input int step, input int last);
    for (int c = first; c <= last; c += step) exp_q[idx].push_back(c);
  endtask

  task automatic push_default(input int ch, input int last);
    push_seq(EN * NUM_CH + ch, 24, 24, last);
    push_seq(RISE * NUM_CH + ch, 1, 24, last);
    push_seq(FALL * NUM_CH + ch, 13, 24, last);
  endtask

  task automatic start_phase(input int last);
`ifndef CLKDIV_LOCK_EN
    push(LOCK_R, 1);
`endif
    mon_until = last;
  endtask

  task automatic end_phase(input int last);
    wait_cyc(last);
    #2;
    for (int i = 0; i < NUM_EV; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL %s: %0d events missing (first at cycle %0d), required 0",
                 ev_name[i], exp_q[i].size(), exp_q[i][0]);
        exp_q[i].delete();
      end
    end
    mon_until = 0;
  endtask

  task automatic drive_load(input int ch, input int val, input int at);
    wait_cyc(at);
    div_val[ch*DIV_W +: DIV_W] = DIV_W'(val);
    div_load[ch] = 1'b1;
    @(negedge clk);
    div_load[ch] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    div_load = '0;
    div_val  = '0;
`ifdef CLKDIV_LOCK_EN
    lock_mon = 1'b0;
`else
    lock_mon = 1'b1;
`endif

    // Default ratio straight out of reset.
    do_reset();
    push_default(0, 75);
    push_default(1, 75);
    start_phase(75);
    end_phase(75);

    // Ratio 5 on channel 0 mid-period; channel 1 untouched.
    do_reset();
    push(EN * NUM_CH + 0, 24);    push_seq(EN * NUM_CH + 0, 29, 5, 40);
    push(ACK * NUM_CH + 0, 24);
    push(RISE * NUM_CH + 0, 1);   push_seq(RISE * NUM_CH + 0, 25, 5, 40);
    push(FALL * NUM_CH + 0, 13);  push_seq(FALL * NUM_CH + 0, 28, 5, 40);
    push_default(1, 40);
    start_phase(40);
    drive_load(0, 5, 10);
    end_phase(40);

    // Ratio 0 then 1 on channel 0, simultaneous ratio 2 on channel 1.
    do_reset();
    push_seq(EN * NUM_CH + 0, 24, 1, 40);
    push(ACK * NUM_CH + 0, 24);   push(ACK * NUM_CH + 0, 31);
    push(RISE * NUM_CH + 0, 1);   push(RISE * NUM_CH + 0, 25);
    push(FALL * NUM_CH + 0, 13);
    push(EN * NUM_CH + 1, 24);    push_seq(EN * NUM_CH + 1, 26, 2, 40);
    push(ACK * NUM_CH + 1, 24);
    push(RISE * NUM_CH + 1, 1);   push_seq(RISE * NUM_CH + 1, 25, 2, 40);
    push(FALL * NUM_CH + 1, 13);  push_seq(FALL * NUM_CH + 1, 26, 2, 40);
    start_phase(40);
    wait_cyc(4);
    div_val  = {DIV_W'(2), DIV_W'(0)};
    div_load = 2'b11;
    @(negedge clk);
    div_load = 2'b00;
    drive_load(0, 1, 29);
    end_phase(40);

    // 7 overwritten by 9 before the wrap; a load on the wrap cycle waits a period.
    do_reset();
    push(EN * NUM_CH + 0, 24);    push(EN * NUM_CH + 0, 33);
    push(EN * NUM_CH + 0, 42);    push_seq(EN * NUM_CH + 0, 46, 4, 56);
    push(ACK * NUM_CH + 0, 24);   push(ACK * NUM_CH + 0, 42);
    push(RISE * NUM_CH + 0, 1);   push(RISE * NUM_CH + 0, 25);
    push(RISE * NUM_CH + 0, 34);  push_seq(RISE * NUM_CH + 0, 43, 4, 56);
    push(FALL * NUM_CH + 0, 13);  push(FALL * NUM_CH + 0, 30);
    push(FALL * NUM_CH + 0, 39);  push_seq(FALL * NUM_CH + 0, 45, 4, 56);
    push_default(1, 56);
    start_phase(56);
    drive_load(0, 7, 4);
    drive_load(0, 9, 9);
    drive_load(0, 4, 32);
    end_phase(56);

    // Reset mid-period with a load pending discards it.
    do_reset();
    drive_load(0, 3, 4);
    wait_cyc(8);
    cmp("pre-reset clkout[0]", int'(clkout[0]), 1);
    do_reset();
    push_default(0, 50);
    push_default(1, 50);
    start_phase(50);
    end_phase(50);

`ifdef CLKDIV_LOCK_EN
    // Lock settles, drops on an ack, and settles again.
    do_reset();
    lock_mon = 1'b1;
    push(LOCK_R, 25);  push(LOCK_F, 48);  push(LOCK_R, 73);
    push(ACK * NUM_CH + 0, 48);
    push_default(0, 75);
    push_default(1, 75);
    start_phase(75);
    drive_load(0, 24, 30);
    end_phase(75);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
